// File: rtl/uart_sched.sv
// Shared-access front end for the single UART: round-robin TX arbitration with frame lock,
// idle-only baud divisor updates and a one-deep RX holding buffer.
module uart_sched #(
    parameter int          NREQ      = 4,
    parameter logic [11:0] DIV_RESET = 12'd103
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [2:0]        grant_id,
    output logic              locked,
    input  logic [11:0]       cfg_divisor,
    input  logic              cfg_we,
    output logic              cfg_pending,
    output logic [11:0]       uart_divisor,
    output logic [7:0]        uart_din,
    output logic              uart_start,
    input  logic              uart_busy,
    input  logic [7:0]        uart_dout,
    input  logic              uart_has_byte,
    output logic              uart_clr_hb,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready
);
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_GUARD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic        locked_q, locked_d;
    logic [7:0]  din_q, din_d;
    logic        guard_q, guard_d;
    logic [11:0] div_q, div_d;
    logic [11:0] pend_val_q, pend_val_d;
    logic        pend_q, pend_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        clr_q, clr_d;

    logic [7:0]  valid_ext;
    logic [7:0]  last_ext;
    logic [7:0]  data_arr [8];
    logic        found;
    logic [2:0]  win;
    logic [2:0]  idx;
    logic        apply;
    logic        capture;

    // Requester vectors widened to 8 so a 3-bit grant index is always in range.
    always_comb begin
        valid_ext = '0;
        last_ext  = '0;
        valid_ext[NREQ-1:0] = req_valid;
        last_ext[NREQ-1:0]  = req_last;
        for (int i = 0; i < 8; i++) data_arr[i] = '0;
        for (int i = 0; i < NREQ; i++) data_arr[i] = req_data[8*i +: 8];
    end

    always_comb begin
        found = 1'b0;
        win   = grant_q;
        idx   = grant_q;
        if (locked_q) begin
            found = valid_ext[grant_q];
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = 3'((int'(grant_q) + k) % NREQ);
                if (!found && valid_ext[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        locked_d   = locked_q;
        din_d      = din_q;
        guard_d    = guard_q;
        div_d      = div_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        clr_d      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_ARB;
            S_ARB: begin
                if (found) begin
                    din_d    = data_arr[win];
                    grant_d  = win;
                    locked_d = !last_ext[win];
                    state_d  = S_START;
                end
            end
            S_START: begin
                guard_d = 1'b1;
                state_d = S_GUARD;
            end
            // UART asserts busy only two cycles after start, so busy is not trusted here.
            S_GUARD: begin
                if (guard_q == 1'b0) state_d = S_DRAIN;
                else                 guard_d = 1'b0;
            end
            S_DRAIN: if (!uart_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        apply = pend_q && !locked_q && !uart_busy && (state_q == S_IDLE || state_q == S_ARB);
        if (apply) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
        end
        if (cfg_we) begin
            pend_val_d = cfg_divisor;
            pend_d     = 1'b1;
        end

        // clr_q blanks the cycle in which the UART's has_byte has not yet dropped.
        capture = uart_has_byte && !rx_valid_q && !clr_q;
        if (capture) begin
            rx_data_d  = uart_dout;
            rx_valid_d = 1'b1;
            clr_d      = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 3'(NREQ - 1);
            locked_q   <= 1'b0;
            din_q      <= '0;
            guard_q    <= 1'b0;
            div_q      <= DIV_RESET;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            locked_q   <= locked_d;
            din_q      <= din_d;
            guard_q    <= guard_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            clr_q      <= clr_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = (state_q == S_START) && (grant_q == 3'(i));
    end

    assign uart_start   = (state_q == S_START);
    assign grant_id     = grant_q;
    assign locked       = locked_q;
    assign cfg_pending  = pend_q;
    assign uart_divisor = div_q;
    assign uart_din     = din_q;
    assign uart_clr_hb  = clr_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
endmodule

// File: tb/tb_uart_sched.sv
// Directed bench for uart_sched with a small behavioural UART (busy two cycles after start,
// optional TX->RX loopback) and per-requester byte queues acting as producers.
module tb_uart_sched;
    localparam int FRAME = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic [2:0]  grant_id;
    logic        locked;
    logic [11:0] cfg_divisor, uart_divisor;
    logic        cfg_we, cfg_pending;
    logic [7:0]  uart_din, uart_dout, rx_data;
    logic        uart_start, uart_busy, uart_has_byte, uart_clr_hb, rx_valid, rx_ready;

    int checks = 0;
    int failures = 0;

    logic [8:0] q [4][$];
    int         cnt = 0;
    logic [7:0] txb = 8'h00;
    logic       lb = 1'b0;
    logic [7:0] log_din [256];
    logic [2:0] log_gid [256];
    logic       log_lock [256];
    int         n_start = 0;
    int         n_clr = 0;

    always #5 clk = ~clk;

    uart_sched #(.NREQ(4), .DIV_RESET(12'd103)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .grant_id(grant_id), .locked(locked),
        .cfg_divisor(cfg_divisor), .cfg_we(cfg_we), .cfg_pending(cfg_pending),
        .uart_divisor(uart_divisor), .uart_din(uart_din), .uart_start(uart_start),
        .uart_busy(uart_busy), .uart_dout(uart_dout), .uart_has_byte(uart_has_byte),
        .uart_clr_hb(uart_clr_hb), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // Behavioural UART: busy from start+2 for FRAME cycles; has_byte drops the cycle after clr_hb.
    assign uart_busy = (cnt >= 2) && (cnt <= FRAME + 1);
    always @(posedge clk) begin
        if (rst) begin
            cnt           <= 0;
            uart_has_byte <= 1'b0;
            uart_dout     <= 8'h00;
        end else begin
            if (uart_start) begin
                cnt <= 1;
                txb <= uart_din;
            end else if (cnt != 0) begin
                cnt <= (cnt == FRAME + 1) ? 0 : cnt + 1;
            end
            if (uart_clr_hb) uart_has_byte <= 1'b0;
            if (lb && cnt == FRAME + 1) begin
                uart_has_byte <= 1'b1;
                uart_dout     <= txb;
            end
        end
    end

    always @(posedge clk) begin
        if (uart_start && n_start < 256) begin
            log_din[n_start]  <= uart_din;
            log_gid[n_start]  <= grant_id;
            log_lock[n_start] <= locked;
            n_start           <= n_start + 1;
        end
        if (uart_clr_hb) n_clr <= n_clr + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic present(input int i);
        logic [8:0] e;
        if (q[i].size() > 0) begin
            e = q[i][0];
            req_valid[i]         = 1'b1;
            req_data[8*i +: 8]   = e[7:0];
            req_last[i]          = e[8];
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
                if (q[i].size() > 0) void'(q[i].pop_front());
                present(i);
            end
        end
    endtask

    task automatic wait_starts(input int target);
        int k = 0;
        while (n_start < target && k < 400) begin
            step();
            k++;
        end
        checks++;
        if (n_start < target) begin
            failures++;
            $display("FAIL wait_starts got=%0d want=%0d", n_start, target);
        end
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (uart_busy && k < 100) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        cfg_we = 1'b0; cfg_divisor = '0; rx_ready = 1'b0;
        repeat (3) step();
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
        checks++; if (uart_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", uart_start); end
        checks++; if (uart_clr_hb !== 1'b0) begin failures++; $display("FAIL rst_clr_hb got=%b exp=0", uart_clr_hb); end
        checks++; if (uart_din !== 8'h00) begin failures++; $display("FAIL rst_din got=%h exp=00", uart_din); end
        checks++; if (grant_id !== 3'd3) begin failures++; $display("FAIL rst_grant got=%0d exp=3", grant_id); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
        checks++; if (cfg_pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0", cfg_pending); end
        checks++; if (uart_divisor !== 12'd103) begin failures++; $display("FAIL rst_divisor got=%0d exp=103", uart_divisor); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    endtask

    task automatic test_arb_order();
        int base = n_start;
        logic [7:0] ed [3];
        logic [2:0] eg [3];
        ed[0] = 8'hA0; ed[1] = 8'hA2; ed[2] = 8'hA3;
        eg[0] = 3'd0;  eg[1] = 3'd2;  eg[2] = 3'd3;
        rst = 1'b1;
        q[0].push_back({1'b1, 8'hA0});
        q[2].push_back({1'b1, 8'hA2});
        q[3].push_back({1'b1, 8'hA3});
        present(0); present(2); present(3);
        step();
        rst = 1'b0;
        step();
        checks++; if (uart_start !== 1'b0) begin failures++; $display("FAIL arb_first_idle start got=%b exp=0", uart_start); end
        step();
        checks++; if (uart_start !== 1'b1 || req_ready !== 4'b0001) begin
            failures++; $display("FAIL arb_latency start=%b ready=%b exp 1/0001", uart_start, req_ready);
        end
        wait_starts(base + 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_gid[base+i] !== eg[i] || log_din[base+i] !== ed[i]) begin
                failures++; $display("FAIL arb_order[%0d] gid=%0d din=%h exp gid=%0d din=%h", i, log_gid[base+i], log_din[base+i], eg[i], ed[i]);
            end
        end
        q[0].push_back({1'b1, 8'hB0});
        present(0);
        wait_starts(base + 4);
        checks++; if (log_gid[base+3] !== 3'd0 || log_din[base+3] !== 8'hB0) begin
            failures++; $display("FAIL arb_wrap gid=%0d din=%h exp gid=0 din=b0", log_gid[base+3], log_din[base+3]);
        end
        repeat (30) step();
    endtask

    task automatic test_frame_lock();
        int base = n_start;
        logic [7:0] ed [4];
        logic [2:0] eg [4];
        logic       el [4];
        ed[0] = 8'h41; ed[1] = 8'h42; ed[2] = 8'h43; ed[3] = 8'hC0;
        eg[0] = 3'd1;  eg[1] = 3'd1;  eg[2] = 3'd1;  eg[3] = 3'd0;
        el[0] = 1'b1;  el[1] = 1'b1;  el[2] = 1'b0;  el[3] = 1'b0;
        q[1].push_back({1'b0, 8'h41});
        q[1].push_back({1'b0, 8'h42});
        q[1].push_back({1'b1, 8'h43});
        q[0].push_back({1'b1, 8'hC0});
        present(0); present(1);
        wait_starts(base + 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_gid[base+i] !== eg[i] || log_din[base+i] !== ed[i] || log_lock[base+i] !== el[i]) begin
                failures++; $display("FAIL frame_lock[%0d] gid=%0d din=%h lock=%b exp gid=%0d din=%h lock=%b",
                    i, log_gid[base+i], log_din[base+i], log_lock[base+i], eg[i], ed[i], el[i]);
            end
        end
        repeat (30) step();
    endtask

    task automatic test_lock_stall();
        int base = n_start;
        q[2].push_back({1'b0, 8'hD2});
        q[3].push_back({1'b1, 8'hD3});
        present(2); present(3);
        wait_starts(base + 1);
        checks++; if (log_gid[base] !== 3'd2 || log_din[base] !== 8'hD2) begin
            failures++; $display("FAIL stall_first gid=%0d din=%h exp gid=2 din=d2", log_gid[base], log_din[base]);
        end
        repeat (50) step();
        checks++; if (n_start !== base + 1) begin failures++; $display("FAIL stall_no_start starts=%0d exp=%0d", n_start, base + 1); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL stall_locked got=%b exp=1", locked); end
        q[2].push_back({1'b1, 8'hE2});
        present(2);
        wait_starts(base + 3);
        checks++; if (log_gid[base+1] !== 3'd2 || log_din[base+1] !== 8'hE2) begin
            failures++; $display("FAIL stall_resume gid=%0d din=%h exp gid=2 din=e2", log_gid[base+1], log_din[base+1]);
        end
        checks++; if (log_gid[base+2] !== 3'd3 || log_din[base+2] !== 8'hD3) begin
            failures++; $display("FAIL stall_next gid=%0d din=%h exp gid=3 din=d3", log_gid[base+2], log_din[base+2]);
        end
        repeat (30) step();
    endtask

    task automatic test_divisor();
        int base = n_start;
        int bad = 0;
        q[0].push_back({1'b1, 8'hF0});
        present(0);
        wait_starts(base + 1);
        repeat (3) step();
        cfg_divisor = 12'd12; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending !== 1'b1 || uart_divisor !== 12'd103) begin
            failures++; $display("FAIL div_defer pending=%b div=%0d exp 1/103", cfg_pending, uart_divisor);
        end
        while (uart_busy && bad < 1000) begin
            if (uart_divisor !== 12'd103 || cfg_pending !== 1'b1) bad = bad + 1000;
            step();
            bad++;
        end
        checks++; if (bad >= 1000) begin failures++; $display("FAIL div_hold_busy bad=%0d exp <1000", bad); end
        step(); step();
        checks++; if (uart_divisor !== 12'd12 || cfg_pending !== 1'b0) begin
            failures++; $display("FAIL div_apply div=%0d pending=%b exp 12/0", uart_divisor, cfg_pending);
        end
        q[1].push_back({1'b1, 8'hF1});
        present(1);
        wait_starts(base + 2);
        repeat (3) step();
        cfg_divisor = 12'd20; cfg_we = 1'b1;
        step();
        cfg_divisor = 12'd30;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending !== 1'b1 || uart_divisor !== 12'd12) begin
            failures++; $display("FAIL div_overwrite_hold pending=%b div=%0d exp 1/12", cfg_pending, uart_divisor);
        end
        wait_not_busy();
        step(); step();
        checks++; if (uart_divisor !== 12'd30 || cfg_pending !== 1'b0) begin
            failures++; $display("FAIL div_last_wins div=%0d pending=%b exp 30/0", uart_divisor, cfg_pending);
        end
        repeat (20) step();
        cfg_divisor = 12'd7; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        step();
        checks++; if (uart_divisor !== 12'd7 || cfg_pending !== 1'b0) begin
            failures++; $display("FAIL div_idle_apply div=%0d pending=%b exp 7/0", uart_divisor, cfg_pending);
        end
    endtask

    task automatic test_rx();
        int base = n_start;
        int base_clr = n_clr;
        int k = 0;
        lb = 1'b1;
        rx_ready = 1'b0;
        q[0].push_back({1'b1, 8'h5A});
        q[0].push_back({1'b1, 8'hA5});
        present(0);
        wait_starts(base + 2);
        repeat (40) step();
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            failures++; $display("FAIL rx_hold valid=%b data=%h exp 1/5a", rx_valid, rx_data);
        end
        checks++; if (n_clr !== base_clr + 1) begin failures++; $display("FAIL rx_clr_one got=%0d exp=%0d", n_clr - base_clr, 1); end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_handshake_clear valid=%b exp=0", rx_valid); end
        while (!rx_valid && k < 6) begin
            step();
            k++;
        end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            failures++; $display("FAIL rx_second valid=%b data=%h exp 1/a5", rx_valid, rx_data);
        end
        repeat (3) step();
        checks++; if (n_clr !== base_clr + 2) begin failures++; $display("FAIL rx_clr_two got=%0d exp=%0d", n_clr - base_clr, 2); end
        lb = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base = n_start;
        q[1].push_back({1'b0, 8'h71});
        present(1);
        wait_starts(base + 1);
        cfg_divisor = 12'd55; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        checks++; if (locked !== 1'b1 || cfg_pending !== 1'b1) begin
            failures++; $display("FAIL mid_pre locked=%b pending=%b exp 1/1", locked, cfg_pending);
        end
        rst = 1'b1;
        step();
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked got=%b exp=0", locked); end
        checks++; if (grant_id !== 3'd3) begin failures++; $display("FAIL mid_grant got=%0d exp=3", grant_id); end
        checks++; if (uart_divisor !== 12'd103 || cfg_pending !== 1'b0) begin
            failures++; $display("FAIL mid_divisor div=%0d pending=%b exp 103/0", uart_divisor, cfg_pending);
        end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (req_ready !== 4'b0 || uart_start !== 1'b0) begin
            failures++; $display("FAIL mid_ready ready=%b start=%b exp 0000/0", req_ready, uart_start);
        end
        for (int i = 0; i < 4; i++) q[i].delete();
        req_valid = '0;
        rst = 1'b0;
        repeat (20) step();
        checks++; if (n_start !== base + 1) begin failures++; $display("FAIL mid_spurious starts=%0d exp=%0d", n_start, base + 1); end
    endtask

    initial begin
        test_reset();
        test_arb_order();
        test_frame_lock();
        test_lock_stall();
        test_divisor();
        test_rx();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_sched.md
# uart_sched

Shared-access controller for the badge's single UART instance. It round-robin arbitrates up to NREQ byte producers onto the UART transmitter and holds a grant across multi-byte frames. It owns the UART baud divisor register and applies changes only when the line is idle. It also drains received bytes into a one-entry valid/ready buffer. It sits between the UART and the CPU/peripheral fabric; nothing else drives the UART's start, din, divisor or clr_hb.

## Interface
- NREQ, 4: number of transmit requesters (2..8).
- DIV_RESET, 12'd103: divisor value loaded at reset.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NREQ  packed bytes.
- req_last  in  NREQ  byte is the last of a frame; releases the lock.
- req_ready  out  NREQ  one-cycle pulse: byte of requester i accepted.
- grant_id  out  3  index of the current or last granted requester.
- locked  out  1  a frame is in progress; the grant is held.
- cfg_divisor  in  12  new divisor value.
- cfg_we  in  1  divisor write strobe.
- cfg_pending  out  1  a divisor write is waiting for idle.
- uart_divisor  out  12  to UART divisor.
- uart_din  out  8  to UART din.
- uart_start  out  1  to UART start; one-cycle pulse.
- uart_busy  in  1  from UART busy.
- uart_dout  in  8  from UART dout.
- uart_has_byte  in  1  from UART has_byte.
- uart_clr_hb  out  1  to UART clr_hb; one-cycle pulse.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data is valid.
- rx_ready  in  1  consumer takes the byte when rx_valid && rx_ready.

## Operation
- Reset values:
  - req_ready=0, uart_start=0, uart_clr_hb=0, uart_din=0.
  - grant_id=NREQ-1, so requester 0 has first priority.
  - locked=0, cfg_pending=0, uart_divisor=DIV_RESET.
  - rx_valid=0, rx_data=0.
  - TX FSM in IDLE.
- TX FSM states:
  - IDLE: the divisor apply happens here. Go to ARB.
  - ARB: candidate set.
    - Unlocked: candidates are all valid requesters. Pick the first valid one searching from grant_id+1 upward, modulo NREQ.
    - Locked: the only candidate is grant_id. Wait in ARB until it is valid; other requesters are never granted.
    - No candidate: stay in ARB.
  - ARB, winner found: the same cycle latches uart_din and grant_id, and sets locked = !req_last[winner]. Go to START.
  - START: uart_start=1 and req_ready[grant_id]=1 for exactly this cycle. Go to GUARD.
  - GUARD: 2-cycle counter. uart_busy is ignored here, because the UART raises busy two cycles after start. Go to DRAIN.
  - DRAIN: stay while uart_busy=1. When uart_busy=0, go to IDLE.
- A producer must hold req_data/req_last stable while req_valid=1 until its req_ready pulse. Dropping req_valid before the grant is legal.
- Divisor writes:
  - A cfg_we write stores cfg_divisor into a pending register and sets cfg_pending.
  - The pending value is copied to uart_divisor in IDLE or ARB when uart_busy=0, and cfg_pending clears on that cycle.
  - The write is held off while locked=1. A frame is never split across baud rates.
  - A later cfg_we overwrites a pending value (last write wins).
  - cfg_we in the same cycle as an apply: the new value becomes pending and is applied at the next idle point.
- RX drain:
  - When uart_has_byte=1, rx_valid=0, and clr_hb was not pulsed in the previous cycle: rx_data<=uart_dout, rx_valid<=1, uart_clr_hb pulses for 1 cycle.
  - The one-cycle post-clear blanking covers the UART's one-cycle has_byte clear latency.
  - rx_valid clears on the rx_valid && rx_ready handshake.
  - Capture and handshake in the same cycle: not allowed. Capture requires rx_valid=0, so the buffer stays at most one deep. A byte waiting inside the UART is captured on the cycle after the handshake.
  - If the UART receives again before draining, it overwrites its byte. That data loss is accepted and not flagged.
- Reset mid-transfer:
  - The FSM returns to IDLE, the lock clears, rx_valid clears, and any pending divisor is discarded.
  - The UART is reset by the same rst.

## Timing
- Minimum arbitration latency: req_valid high in cycle t with the FSM in ARB gives req_ready and uart_start in t+1.
- Back-to-back bytes: the next ARB decision is made 1 cycle after busy falls (DRAIN→IDLE→ARB), then START follows.
- Per-byte overhead beyond the UART's 10-bit frame is 5 cycles.
- Divisor apply completes no later than the IDLE cycle after the current frame ends.
- RX: uart_has_byte rising at t gives rx_valid and uart_clr_hb at t+1.

## Test plan
- Arbitration order: NREQ=4, requesters 0,2,3 all valid with last=1 from reset. Grants must be 0,2,3, then 0 again if it is re-asserted. Each uart_start sees uart_din equal to that requester's byte.
- Frame lock:
  - Req 1 sends 0x41, 0x42, 0x43 with last only on 0x43, while req 0 is held valid throughout.
  - All three bytes go out consecutively, with locked=1 until 0x43's START.
  - Req 0's byte follows.
- Lock stall: req 2 sends a non-last byte, then drops req_valid for 50 cycles while req 3 is valid. No uart_start occurs until req 2 returns.
- Divisor defer:
  - cfg_we with 12'd12 while a byte is in DRAIN: uart_divisor stays 103 and cfg_pending=1 until busy falls.
  - Then uart_divisor=12 and cfg_pending=0.
- RX drain/backpressure:
  - Loop the UART TX to its RX and send 0x5A, 0xA5 with rx_ready=0.
  - rx_data=0x5A is held. After rx_ready=1 for one cycle, rx_data=0xA5 follows.
  - Exactly one uart_clr_hb pulse per byte.
- Reset mid-frame: assert rst during GUARD of a locked frame. Next cycle: locked=0, grant_id=NREQ-1, uart_divisor=DIV_RESET, rx_valid=0, and no spurious req_ready.
